// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO hub: page/word decode, STATUS layout, IRQ readback layout.
package mmio_pkg;

    typedef enum logic [1:0] {
        GW_BTN      = 2'd0,
        GW_BTN_EDGE = 2'd1,
        GW_UART     = 2'd2,
        GW_IRQ      = 2'd3
    } glb_word_e;

    typedef enum logic [1:0] {
        CW_CMD_LO = 2'd0,
        CW_CMD_HI = 2'd1,
        CW_STATUS = 2'd2,
        CW_RSVD   = 2'd3
    } ch_word_e;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_e;

    localparam int CH_IDX_LSB = 2;
    localparam int CH_IDX_W   = 4;

    localparam int START_BIT   = 31;
    localparam int ST_BUSY_BIT = 31;
    localparam int ST_RV_BIT   = 30;
    localparam int ST_OV_BIT   = 29;
    localparam int ST_ERR_BIT  = 28;

    localparam logic [7:0] RESP_RST = 8'hFF;

    // IRQ word: write bit 31 = button enable, bits [NUM_CH-1:0] = channel enables.
    // Read: [31] button enable, [30:16] channel enables 0..14, [15:0] channel pending.
    localparam int IRQ_MASK_BTN_BIT    = 31;
    localparam int IRQ_RD_MASK_CH_LSB  = 16;
    localparam int IRQ_RD_MASK_CH_MAX  = 15;
    localparam int IRQ_RD_PEND_CH_LSB  = 0;

    function automatic logic [31:0] pack_status(input logic busy, input logic rv,
                                                input logic ov, input logic err,
                                                input logic [7:0] resp);
        logic [31:0] s;
        s              = '0;
        s[ST_BUSY_BIT] = busy;
        s[ST_RV_BIT]   = rv;
        s[ST_OV_BIT]   = ov;
        s[ST_ERR_BIT]  = err;
        s[7:0]         = resp;
        return s;
    endfunction

endpackage

// File: rtl/mmio_channel.sv
// One command/response peripheral channel: command registers, start handshake,
// response capture with overrun tracking and the channel's register read mux.
module mmio_channel
    import mmio_pkg::*;
#(
    parameter int CMD_W = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    input  logic             status_rd_i,
    input  logic [1:0]       word_i,
    input  logic             ack_i,
    input  logic             resp_valid_i,
    input  logic [7:0]       resp_i,
    output logic [CMD_W-1:0] cmd_o,
    output logic             req_o,
    output logic             resp_valid_o,
    output logic [31:0]      rdata_o
);

    localparam int HI_W = CMD_W - 32;

    ch_state_e         state_q, state_d;
    logic [31:0]       lo_q, lo_d;
    logic [HI_W-1:0]   hi_q, hi_d;
    logic [7:0]        resp_q, resp_d;
    logic              rv_q, rv_d;
    logic              ov_q, ov_d;
    logic              err_q, err_d;
    logic              busy;
    logic              unused_wdata;

    assign busy         = (state_q == CH_BUSY);
    assign unused_wdata = ^wdata_i;

    // NOTE: every _d starts as its _q so no branch can leave a latch behind.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        resp_d  = resp_q;
        rv_d    = rv_q;
        ov_d    = ov_q;
        err_d   = err_q;

        // A busy channel keeps its command stable for the peripheral.
        if ((wr_lo_i || wr_hi_i) && busy) begin
            err_d = 1'b1;
        end else if (status_rd_i) begin
            err_d = 1'b0;
        end

        if (wr_lo_i && !busy) begin
            lo_d = wdata_i;
        end
        if (wr_hi_i && !busy) begin
            hi_d = wdata_i[HI_W-1:0];
            if (wdata_i[START_BIT]) begin
                state_d = CH_BUSY;
            end
        end
        if (busy && ack_i) begin
            state_d = CH_IDLE;
        end

        // A response landing on the same cycle as the STATUS read wins.
        if (resp_valid_i) begin
            resp_d = resp_i;
            rv_d   = 1'b1;
            if (rv_q && !status_rd_i) begin
                ov_d = 1'b1;
            end
        end else if (status_rd_i) begin
            rv_d = 1'b0;
            ov_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CH_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            resp_q  <= RESP_RST;
            rv_q    <= 1'b0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            resp_q  <= resp_d;
            rv_q    <= rv_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (ch_word_e'(word_i))
            CW_CMD_LO: rdata_o = lo_q;
            CW_CMD_HI: rdata_o = 32'(hi_q);
            CW_STATUS: rdata_o = pack_status(busy, rv_q, ov_q, err_q, resp_q);
            CW_RSVD:   rdata_o = '0;
        endcase
    end

    assign cmd_o        = {hi_q, lo_q};
    assign req_o        = busy;
    assign resp_valid_o = rv_q;

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped IO hub: RAM/IO split, button/UART/IRQ globals and NUM_CH command channels.
// Define MMIO_HUB_IRQ_EN to build the maskable interrupt; otherwise irq is tied low.
module mmio_hub
    import mmio_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int NUM_CH = 4,
    parameter int CMD_W  = 48,
    parameter int BTN_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [31:0]             data_in,
    output logic [31:0]             data_out,
    input  logic                    write_en,
    input  logic                    read_en,
    input  logic [31:0]             ram_out,
    output logic                    ram_write,
    input  logic [BTN_W-1:0]        btn,
    output logic [NUM_CH*CMD_W-1:0] ch_cmd,
    output logic [NUM_CH-1:0]       ch_req,
    input  logic [NUM_CH-1:0]       ch_ack,
    input  logic [NUM_CH-1:0]       ch_resp_valid,
    input  logic [NUM_CH*8-1:0]     ch_resp,
    output logic                    uart_set_addr,
    output logic [11:0]             uart_addr,
    input  logic [7:0]              uart_last_byte,
    output logic                    irq
);

    logic                io_sel;
    logic                ch_page;
    logic [1:0]          word;
    logic [CH_IDX_W-1:0] ch_idx;
    logic                glb_wr;

    assign io_sel    = addr[ADDR_W-1];
    assign ch_page   = addr[ADDR_W-2];
    assign word      = addr[1:0];
    assign ch_idx    = addr[CH_IDX_LSB +: CH_IDX_W];
    assign glb_wr    = write_en & io_sel & ~ch_page;
    assign ram_write = write_en & ~io_sel;

    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] ch_rv;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [31:0]       ch_rd;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        // Full 4-bit compare: indices at or above NUM_CH hit nothing.
        assign ch_hit[n] = io_sel & ch_page & (ch_idx == CH_IDX_W'(n));

        mmio_channel #(.CMD_W(CMD_W)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .wr_lo_i      (write_en & ch_hit[n] & (word == CW_CMD_LO)),
            .wr_hi_i      (write_en & ch_hit[n] & (word == CW_CMD_HI)),
            .wdata_i      (data_in),
            .status_rd_i  (read_en & ch_hit[n] & (word == CW_STATUS)),
            .word_i       (word),
            .ack_i        (ch_ack[n]),
            .resp_valid_i (ch_resp_valid[n]),
            .resp_i       (ch_resp[n*8 +: 8]),
            .cmd_o        (ch_cmd[n*CMD_W +: CMD_W]),
            .req_o        (ch_req[n]),
            .resp_valid_o (ch_rv[n]),
            .rdata_o      (ch_rdata[n])
        );
    end

    always_comb begin
        ch_rd = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_hit[n]) begin
                ch_rd = ch_rdata[n];
            end
        end
    end

    logic [BTN_W-1:0] btn_prev_q, btn_prev_d;
    logic [BTN_W-1:0] btn_edge_q, btn_edge_d;
    logic             uart_set_q, uart_set_d;
    logic [11:0]      uart_addr_q, uart_addr_d;

    always_comb begin
        btn_prev_d = btn;
        btn_edge_d = btn_edge_q;
        if (glb_wr && (word == GW_BTN_EDGE)) begin
            btn_edge_d = btn_edge_q & ~data_in[BTN_W-1:0];
        end
        // Applied after the clear so a coincident rising edge keeps its flag.
        btn_edge_d  = btn_edge_d | (btn & ~btn_prev_q);
        uart_set_d  = glb_wr && (word == GW_UART);
        uart_addr_d = uart_set_d ? data_in[11:0] : uart_addr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev_q  <= '0;
            btn_edge_q  <= '0;
            uart_set_q  <= 1'b0;
            uart_addr_q <= '0;
        end else begin
            btn_prev_q  <= btn_prev_d;
            btn_edge_q  <= btn_edge_d;
            uart_set_q  <= uart_set_d;
            uart_addr_q <= uart_addr_d;
        end
    end

    assign uart_set_addr = uart_set_q;
    assign uart_addr     = uart_addr_q;

    logic [31:0] irq_word;

`ifdef MMIO_HUB_IRQ_EN
    logic [NUM_CH-1:0] mask_ch_q, mask_ch_d;
    logic              mask_btn_q, mask_btn_d;
    logic              irq_q, irq_d;

    always_comb begin
        mask_ch_d  = mask_ch_q;
        mask_btn_d = mask_btn_q;
        if (glb_wr && (word == GW_IRQ)) begin
            mask_ch_d  = data_in[NUM_CH-1:0];
            mask_btn_d = data_in[IRQ_MASK_BTN_BIT];
        end
        irq_d = (|(mask_ch_q & ch_rv)) | (mask_btn_q & (|btn_edge_q));

        irq_word                   = '0;
        irq_word[IRQ_MASK_BTN_BIT] = mask_btn_q;
        for (int i = 0; i < NUM_CH; i++) begin
            irq_word[IRQ_RD_PEND_CH_LSB + i] = ch_rv[i];
            if (i < IRQ_RD_MASK_CH_MAX) begin
                irq_word[IRQ_RD_MASK_CH_LSB + i] = mask_ch_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_ch_q  <= '0;
            mask_btn_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mask_ch_q  <= mask_ch_d;
            mask_btn_q <= mask_btn_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq_word = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        data_out = '0;
        if (!io_sel) begin
            data_out = ram_out;
        end else if (ch_page) begin
            data_out = ch_rd;
        end else begin
            case (glb_word_e'(word))
                GW_BTN:      data_out = 32'(btn);
                GW_BTN_EDGE: data_out = 32'(btn_edge_q);
                GW_UART:     data_out = {24'b0, uart_last_byte};
                GW_IRQ:      data_out = irq_word;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr, data_in, ch_rv};

endmodule

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning word-address width; addr[ADDR_W-1]=1 selects IO space, 0 selects RAM.
REQ-002 SHALL have parameter NUM_CH, default 4, meaning number of command/response peripheral channels (1..16).
REQ-003 SHALL have parameter CMD_W, default 48, meaning per-channel command width (33..63); low 32 bits in CMD_LO, remaining CMD_W-32 bits in CMD_HI.
REQ-004 SHALL have parameter BTN_W, default 5, meaning button input width (1..31).
REQ-005 SHALL have port clk input 1, the single clock; every register updates on its rising edge.
REQ-006 SHALL have port reset input 1, asynchronous, active-high reset.
REQ-007 SHALL have ports addr input ADDR_W, data_in input 32, data_out output 32, write_en input 1, read_en input 1 (CPU side).
REQ-008 SHALL have ports ram_out input 32 and ram_write output 1, where ram_write = write_en & ~addr[ADDR_W-1].
REQ-009 SHALL have port btn input BTN_W, raw buttons, already synchronised.
REQ-010 SHALL have ports ch_cmd output NUM_CH*CMD_W, ch_req output NUM_CH, ch_ack input NUM_CH, ch_resp_valid input NUM_CH, ch_resp input NUM_CH*8 (channel n occupies slice n).
REQ-011 SHALL have ports uart_set_addr output 1, uart_addr output 12, uart_last_byte input 8.
REQ-012 SHALL have port irq output 1.

Function
REQ-013 IO decode SHALL be: addr[ADDR_W-2]=0 global page, word addr[1:0]; addr[ADDR_W-2]=1 channel page, ch = addr[5:2], word = addr[1:0].
REQ-014 Global words SHALL be: 0 BTN live (read-only); 1 BTN_EDGE sticky rising-edge flags, write-1-to-clear; 2 UART (read {24'b0,uart_last_byte}, write pulses uart_set_addr one cycle with uart_addr = data_in[11:0] registered); 3 IRQ_MASK/status.
REQ-015 Channel words SHALL be: 0 CMD_LO r/w; 1 CMD_HI r/w, with write of bit31=1 issuing start; 2 STATUS {busy[31], resp_valid[30], overrun[29], cmd_err[28], 20'b0, resp[7:0]}; 3 reserved, reads 0.
REQ-016 data_out SHALL be combinational from addr and registered state (zero-latency read); RAM space returns ram_out.
REQ-017 Start handshake: start write sets ch_req[n]=1 the next cycle; ch_req stays 1 until the cycle ch_ack[n]=1 is sampled, then clears; busy = ch_req[n].
REQ-018 Write to CMD_LO/CMD_HI of a busy channel SHALL be ignored and set cmd_err; cmd_err clears on STATUS read (read_en).
REQ-019 ch_resp_valid[n] SHALL capture ch_resp[n] into resp, set resp_valid; arrival while resp_valid=1 additionally sets overrun.
REQ-020 STATUS read with read_en SHALL clear resp_valid and overrun; simultaneous new response wins (resp_valid=1, data updated, overrun unchanged).
REQ-021 BTN_EDGE bit SHALL set on 0->1 of btn; simultaneous edge and W1C SHALL leave the bit set.
REQ-022 Channel index >= NUM_CH SHALL read 0 and ignore writes; IO writes SHALL never assert ram_write.

Reset
REQ-023 On reset: all CMD registers 0, ch_req 0, resp 8'hFF, resp_valid/overrun/cmd_err 0, BTN_EDGE 0, btn history 0, IRQ_MASK 0, uart_set_addr 0, uart_addr 0, irq 0.
REQ-024 Reset mid-handshake SHALL drop ch_req immediately; a later ch_ack SHALL be ignored.

Configuration
REQ-025 With MMIO_HUB_IRQ_EN defined: IRQ_MASK bits [NUM_CH-1:0] enable per-channel resp_valid, bit 31 enables any BTN_EDGE; irq registered = OR of enabled pending sources; read returns mask in [31:16] position-packed as {mask_btn,pending...} per package layout.
REQ-026 Without MMIO_HUB_IRQ_EN: irq tied 0, global word 3 reads 0, writes ignored.

Structure
REQ-027 Shared package mmio_pkg SHALL hold page/word offset constants, STATUS bit positions and resp reset value 8'hFF.
REQ-028 Per-channel logic SHALL be sub-module mmio_channel, instantiated NUM_CH times via generate.

Verification
REQ-029 Write CMD_LO=0x11223344, CMD_HI=0x80000055 to ch1 -> ch_cmd slice1=0x005511223344, ch_req[1]=1 next cycle, clears cycle after ch_ack[1].
REQ-030 Write CMD_LO to ch1 while busy -> CMD unchanged, STATUS bit28=1; STATUS read -> bit28=0.
REQ-031 Two ch_resp_valid pulses (0xA5 then 0x3C) without read -> STATUS=0x6000003C; read then re-read -> 0x0000003C.
REQ-032 btn[2] rises -> BTN_EDGE=0x4; write 0x4 same cycle as btn[0] rise -> BTN_EDGE=0x1.
REQ-033 Assert reset while ch_req[0]=1 -> ch_req=0, resp=0xFF, later ch_ack ignored.
REQ-034 MMIO_HUB_IRQ_EN: mask=0x1, ch0 response -> irq=1 one cycle later; STATUS read -> irq=0.
